// File: rtl/ov7670_pkg.sv
// ---------------------------------------------------------------------------
// ov7670_pkg
// Shared definitions for the OV7670 SCCB write path.
//   - sccb_state_t   : frame sequencer states
//   - OV7670_WRITE_ID: 8-bit write address of the camera
//   - *_Q            : quarter-bit counts for each frame phase
//   - FRAME_BITS     : id + reg + value bytes plus three don't-care bits
//   - DC_BIT_*       : send-order indices of the don't-care (ACK) bits
// ---------------------------------------------------------------------------
package ov7670_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        BITS,
        STOP,
        GAP
    } sccb_state_t;

    localparam logic [7:0] OV7670_WRITE_ID = 8'h42;

    localparam int START_Q    = 2;
    localparam int BIT_Q      = 4;
    localparam int STOP_Q     = 3;
    localparam int FRAME_BITS = 27;

    localparam int DC_BIT_A = 8;
    localparam int DC_BIT_B = 17;
    localparam int DC_BIT_C = 26;

    // True for the bit slots where the master releases siod so the slave
    // can answer; whatever the slave drives there is ignored.
    function automatic logic is_dont_care(input logic [4:0] idx);
        return (idx == 5'(DC_BIT_A)) || (idx == 5'(DC_BIT_B)) || (idx == 5'(DC_BIT_C));
    endfunction

endpackage

// File: rtl/sccb_quarter_tick.sv
// ---------------------------------------------------------------------------
// sccb_quarter_tick
// Quarter-bit timebase for the SCCB master. Counts 0..CLK_DIV-1 while enabled
// and pulses qtick for one clk on the last count. Held at 0 when disabled so
// every frame starts with a full quarter.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   en    : count enable (high while a frame is in progress)
//   qtick : one-clk pulse at the end of each quarter
// ---------------------------------------------------------------------------
module sccb_quarter_tick #(
    parameter int CLK_DIV = 125
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic qtick
);

    localparam logic [15:0] LAST = 16'(CLK_DIV - 1);

    logic [15:0] cnt;

    // Free-running divider that wraps at the end of each quarter and is
    // parked at zero whenever the sequencer is idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!en || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

    // With CLK_DIV=1 LAST is zero, so the tick is high on every enabled cycle.
    assign qtick = en && (cnt == LAST);

endmodule

// File: rtl/ov7670_sccb_sender.sv
// ---------------------------------------------------------------------------
// ov7670_sccb_sender
// SCCB 3-phase write master fed by the OV7670 register-table ROM. Each frame
// is: start, id, don't-care, register, don't-care, value, don't-care, stop,
// followed by GAP_Q idle quarters.
//   clk     : system clock
//   rst_n   : asynchronous active-low reset
//   send    : level request, a frame starts when high in IDLE
//   id      : device write address, latched at frame start
//   command : {register, value}, latched at frame start
//   taken   : one-clk pulse on the latch cycle (ROM advance)
//   busy    : high from the latch cycle until the gap has elapsed
//   sioc    : SCCB clock, push-pull
//   siod    : SCCB data, driven 0/1 or released (Z)
// ---------------------------------------------------------------------------
module ov7670_sccb_sender
    import ov7670_pkg::*;
#(
    parameter int CLK_DIV = 125,
    parameter int GAP_Q   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        send,
    input  logic [7:0]  id,
    input  logic [15:0] command,
    output logic        taken,
    output logic        busy,
    output logic        sioc,
    inout  wire         siod
);

    sccb_state_t           state;
    logic [7:0]            qcnt;
    logic [4:0]            bitcnt;
    logic [FRAME_BITS-1:0] shift;
    logic                  siod_out;
    logic                  siod_oe;
    logic                  qtick;
    logic                  tick_en;

    assign tick_en = (state != IDLE);

    sccb_quarter_tick #(
        .CLK_DIV(CLK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (tick_en),
        .qtick(qtick)
    );

    assign siod = siod_oe ? siod_out : 1'bz;

    // Frame sequencer. Each register assignment below sets the bus levels for
    // the quarter being entered, so sioc/siod change one clk after qtick and
    // every quarter lasts exactly CLK_DIV clks. The don't-care slots carry a
    // dummy bit in the shift register; only siod_oe matters there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            qcnt     <= '0;
            bitcnt   <= '0;
            shift    <= '0;
            sioc     <= 1'b1;
            siod_out <= 1'b1;
            siod_oe  <= 1'b0;
            taken    <= 1'b0;
            busy     <= 1'b0;
        end else begin
            taken <= 1'b0;
            case (state)
                IDLE: begin
                    if (send) begin
                        shift    <= {id, 1'b1, command[15:8], 1'b1, command[7:0], 1'b1};
                        taken    <= 1'b1;
                        busy     <= 1'b1;
                        state    <= START;
                        qcnt     <= '0;
                        sioc     <= 1'b1;
                        siod_out <= 1'b1;
                        siod_oe  <= 1'b1;
                    end
                end
                START: begin
                    if (qtick) begin
                        if (qcnt == 8'(START_Q - 1)) begin
                            state    <= BITS;
                            qcnt     <= '0;
                            bitcnt   <= '0;
                            sioc     <= 1'b0;
                            siod_out <= shift[FRAME_BITS-1];
                            siod_oe  <= !is_dont_care(5'd0);
                        end else begin
                            qcnt     <= qcnt + 8'd1;
                            siod_out <= 1'b0;
                        end
                    end
                end
                BITS: begin
                    if (qtick) begin
                        if (qcnt == 8'(BIT_Q - 1)) begin
                            qcnt <= '0;
                            sioc <= 1'b0;
                            if (bitcnt == 5'(FRAME_BITS - 1)) begin
                                state    <= STOP;
                                siod_out <= 1'b0;
                                siod_oe  <= 1'b1;
                            end else begin
                                bitcnt   <= bitcnt + 5'd1;
                                shift    <= shift << 1;
                                siod_out <= shift[FRAME_BITS-2];
                                siod_oe  <= !is_dont_care(bitcnt + 5'd1);
                            end
                        end else begin
                            // sioc rises halfway through the bit, data held.
                            if (qcnt == 8'd1) begin
                                sioc <= 1'b1;
                            end
                            qcnt <= qcnt + 8'd1;
                        end
                    end
                end
                STOP: begin
                    if (qtick) begin
                        if (qcnt == 8'(STOP_Q - 1)) begin
                            qcnt <= '0;
                            if (GAP_Q == 0) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end else begin
                                state <= GAP;
                            end
                        end else begin
                            // q1 raises sioc with data low, q2 releases data
                            // so the pull-up makes the stop edge.
                            if (qcnt == 8'd0) begin
                                sioc <= 1'b1;
                            end else begin
                                siod_oe <= 1'b0;
                            end
                            qcnt <= qcnt + 8'd1;
                        end
                    end
                end
                GAP: begin
                    if (qtick) begin
                        if (qcnt == 8'(GAP_Q - 1)) begin
                            qcnt  <= '0;
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            qcnt <= qcnt + 8'd1;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    sioc    <= 1'b1;
                    siod_oe <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ov7670_sccb_sender.sv
// ---------------------------------------------------------------------------
// tb_ov7670_sccb_sender
// Two sender instances (CLK_DIV=4/GAP_Q=4 and CLK_DIV=1/GAP_Q=0) checked
// every cycle against a waveform model built from the frame description,
// plus directed checks of decoded bytes, frame lengths and bus events.
// A released siod reads high through the pull-ups.
// ---------------------------------------------------------------------------
module tb_ov7670_sccb_sender;

    localparam int DIV_A = 4;
    localparam int GAP_A = 4;
    localparam int DIV_B = 1;
    localparam int GAP_B = 0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  send;
    logic [7:0]  idV  [2];
    logic [15:0] cmdV [2];
    logic [1:0]  taken;
    logic [1:0]  busy;
    logic [1:0]  sioc;
    wire         siodA;
    wire         siodB;
    wire  [1:0]  siodV;

    pullup (siodA);
    pullup (siodB);
    assign siodV = {siodB, siodA};

    int vectors     = 0;
    int miscompares = 0;
    int cycleNo     = 0;

    ov7670_sccb_sender #(.CLK_DIV(DIV_A), .GAP_Q(GAP_A)) dutA (
        .clk(clk), .rst_n(rst_n), .send(send[0]), .id(idV[0]), .command(cmdV[0]),
        .taken(taken[0]), .busy(busy[0]), .sioc(sioc[0]), .siod(siodA)
    );

    ov7670_sccb_sender #(.CLK_DIV(DIV_B), .GAP_Q(GAP_B)) dutB (
        .clk(clk), .rst_n(rst_n), .send(send[1]), .id(idV[1]), .command(cmdV[1]),
        .taken(taken[1]), .busy(busy[1]), .sioc(sioc[1]), .siod(siodB)
    );

    always #5 clk = ~clk;

    function automatic int divOf(input int k);
        return (k == 0) ? DIV_A : DIV_B;
    endfunction

    function automatic int frameClks(input int k);
        return (113 + ((k == 0) ? GAP_A : GAP_B)) * divOf(k);
    endfunction

    // Bus levels for quarter q of a frame: 2 start quarters, 27 bits of
    // 4 quarters, 3 stop quarters, then idle levels through the gap.
    function automatic void expQuarter(input int q, input logic [7:0] fid, input logic [15:0] fcmd,
                                       output logic eSioc, output logic eSiod);
        int b;
        int ph;
        int slot;
        logic [7:0] byteV;
        eSioc = 1'b1;
        eSiod = 1'b1;
        if (q == 1) begin
            eSiod = 1'b0;
        end else if (q >= 2 && q < 110) begin
            b     = (q - 2) / 4;
            ph    = (q - 2) % 4;
            slot  = b % 9;
            eSioc = (ph >= 2);
            if (slot != 8) begin
                byteV = (b / 9 == 0) ? fid : ((b / 9 == 1) ? fcmd[15:8] : fcmd[7:0]);
                eSiod = byteV[7 - slot];
            end
        end else if (q == 110) begin
            eSioc = 1'b0;
            eSiod = 1'b0;
        end else if (q == 111) begin
            eSiod = 1'b0;
        end
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, actual, expected, cycleNo);
        end
    endtask

    // Reference model: frame position per instance, counted in clks from
    // the cycle the request is accepted.
    logic        mBusy  [2];
    logic        mTaken [2];
    int          mCnt   [2];
    logic [7:0]  mId    [2];
    logic [15:0] mCmd   [2];

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                mBusy[k]  <= 1'b0;
                mTaken[k] <= 1'b0;
                mCnt[k]   <= 0;
            end else if (!mBusy[k]) begin
                mTaken[k] <= send[k];
                if (send[k]) begin
                    mBusy[k] <= 1'b1;
                    mCnt[k]  <= 0;
                    mId[k]   <= idV[k];
                    mCmd[k]  <= cmdV[k];
                end
            end else begin
                mTaken[k] <= 1'b0;
                if (mCnt[k] + 1 == frameClks(k)) begin
                    mBusy[k] <= 1'b0;
                end else begin
                    mCnt[k] <= mCnt[k] + 1;
                end
            end
        end
    end

    // Event monitor state: captured data at sioc rising edges, start/stop
    // conditions, taken pulses and taken-to-idle durations.
    logic capA [$];
    logic capB [$];
    int   startCycA [$];
    int   stopCycA  [$];
    int   takenCnt [2];
    int   startEv  [2];
    int   stopEv   [2];
    int   tStart   [2];
    int   dur      [2];
    logic prevSioc [2];
    logic prevSiod [2];
    logic prevBusy [2];

    // Compare process: every cycle, both instances against the model, then
    // bookkeeping for the directed checks.
    always @(negedge clk) begin
        logic eS;
        logic eD;
        cycleNo++;
        for (int k = 0; k < 2; k++) begin
            eS = 1'b1;
            eD = 1'b1;
            if (mBusy[k]) begin
                expQuarter(mCnt[k] / divOf(k), mId[k], mCmd[k], eS, eD);
            end
            checkOutput($sformatf("sioc%0d", k), sioc[k], eS);
            checkOutput($sformatf("siod%0d", k), siodV[k], eD);
            checkOutput($sformatf("busy%0d", k), busy[k], mBusy[k]);
            checkOutput($sformatf("taken%0d", k), taken[k], mTaken[k]);
            if (rst_n) begin
                if (taken[k]) begin
                    takenCnt[k]++;
                    tStart[k] = cycleNo;
                end
                if (prevBusy[k] && !busy[k]) dur[k] = cycleNo - tStart[k];
                if (!prevSioc[k] && sioc[k]) begin
                    if (k == 0) capA.push_back(siodV[k]);
                    else        capB.push_back(siodV[k]);
                end
                if (prevSioc[k] && sioc[k] && prevSiod[k] && !siodV[k]) begin
                    startEv[k]++;
                    if (k == 0) startCycA.push_back(cycleNo);
                end
                if (prevSioc[k] && sioc[k] && !prevSiod[k] && siodV[k]) begin
                    stopEv[k]++;
                    if (k == 0) stopCycA.push_back(cycleNo);
                end
            end
            prevSioc[k] = sioc[k];
            prevSiod[k] = siodV[k];
            prevBusy[k] = busy[k];
        end
    end

    // Register-table ROM stand-in for instance A: steps its output two
    // clks after each taken pulse.
    logic romOn = 1'b0;
    logic romAdv1;
    logic romAdv2;
    int   romIdx;

    function automatic logic [15:0] romTable(input int i);
        case (i)
            0:       return 16'h1280;
            1:       return 16'h1200;
            default: return 16'h1100;
        endcase
    endfunction

    always @(negedge clk) begin
        if (romOn) begin
            if (romAdv2) begin
                romIdx    = romIdx + 1;
                cmdV[0]   = romTable(romIdx);
            end
            romAdv2 = romAdv1;
            romAdv1 = taken[0];
        end
    end

    function automatic logic capOf(input int k, input int i);
        if (k == 0) return (i < capA.size()) ? capA[i] : 1'bx;
        return (i < capB.size()) ? capB[i] : 1'bx;
    endfunction

    function automatic int qAt(input int which, input int i);
        if (which == 0) return (i < startCycA.size()) ? startCycA[i] : -1;
        return (i < stopCycA.size()) ? stopCycA[i] : -1;
    endfunction

    task automatic clearMon();
        capA.delete();
        capB.delete();
        startCycA.delete();
        stopCycA.delete();
        for (int k = 0; k < 2; k++) begin
            takenCnt[k] = 0;
            startEv[k]  = 0;
            stopEv[k]   = 0;
            dur[k]      = -1;
        end
    endtask

    task automatic applyStimulus(input int k, input logic [7:0] fid, input logic [15:0] fcmd);
        @(negedge clk);
        idV[k]  = fid;
        cmdV[k] = fcmd;
        send[k] = 1'b1;
    endtask

    task automatic waitTaken(input int k);
        int n = 0;
        while (taken[k] !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("takenSeen", taken[k], 1'b1);
    endtask

    task automatic waitIdle(input int k);
        int n = 0;
        while (busy[k] !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("busyDrops", busy[k], 1'b0);
        @(negedge clk);
    endtask

    // Decoded frame f: 27 bits captured at sioc rises, then the stop
    // condition's sioc rise with data still low.
    task automatic checkFrame(input int k, input int f, input logic [7:0] eId, input logic [15:0] eCmd);
        logic [26:0] got;
        int base;
        base = f * 28;
        got  = '0;
        for (int i = 0; i < 27; i++) got[26 - i] = capOf(k, base + i);
        checkOutput("frameId", got[26:19], eId);
        checkOutput("dcBit8", got[18], 1'b1);
        checkOutput("frameReg", got[17:10], eCmd[15:8]);
        checkOutput("dcBit17", got[9], 1'b1);
        checkOutput("frameVal", got[8:1], eCmd[7:0]);
        checkOutput("dcBit26", got[0], 1'b1);
        checkOutput("stopRiseLow", capOf(k, base + 27), 1'b0);
    endtask

    initial begin
        $display("[TB] watchdog armed");
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, want summary");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n   = 1'b0;
        send    = 2'b00;
        idV[0]  = 8'h42;
        idV[1]  = 8'h42;
        cmdV[0] = 16'h1280;
        cmdV[1] = 16'h1280;
        for (int k = 0; k < 2; k++) begin
            prevSioc[k] = 1'b1;
            prevSiod[k] = 1'b1;
            prevBusy[k] = 1'b0;
        end
        clearMon();

        // Reset state.
        repeat (3) @(negedge clk);
        checkOutput("rstSioc", sioc[0], 1'b1);
        checkOutput("rstSiod", siodA, 1'b1);
        checkOutput("rstBusy", busy[0], 1'b0);
        checkOutput("rstTaken", taken[0], 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single frame 0x42 / 0x12 / 0x80 with start/stop conditions.
        applyStimulus(0, 8'h42, 16'h1280);
        waitTaken(0);
        send[0] = 1'b0;
        waitIdle(0);
        checkOutput("takenPulses1", takenCnt[0], 1);
        checkOutput("frameClksA", dur[0], 468);
        checkFrame(0, 0, 8'h42, 16'h1280);
        checkOutput("startConds", startEv[0], 1);
        checkOutput("stopConds", stopEv[0], 1);
        checkOutput("stopAfterStart", qAt(1, 0) > qAt(0, 0), 1'b1);

        // Back-to-back frames fed by the ROM stand-in.
        clearMon();
        romIdx  = 0;
        romAdv1 = 1'b0;
        romAdv2 = 1'b0;
        romOn   = 1'b1;
        applyStimulus(0, 8'h42, 16'h1280);
        waitTaken(0);
        @(negedge clk);
        waitTaken(0);
        @(negedge clk);
        waitTaken(0);
        send[0] = 1'b0;
        waitIdle(0);
        romOn = 1'b0;
        checkOutput("takenPulses3", takenCnt[0], 3);
        checkFrame(0, 0, 8'h42, 16'h1280);
        checkFrame(0, 1, 8'h42, 16'h1200);
        checkFrame(0, 2, 8'h42, 16'h1100);
        // stop quarter (4) + 4 gap quarters (16) + idle clk (1) + start q0 (4)
        checkOutput("gapStopStart1", qAt(0, 1) - qAt(1, 0), 25);
        checkOutput("gapStopStart2", qAt(0, 2) - qAt(1, 1), 25);

        // Inputs changing mid-frame do not disturb the latched frame.
        clearMon();
        applyStimulus(0, 8'h42, 16'h1280);
        waitTaken(0);
        send[0] = 1'b0;
        repeat (100) @(negedge clk);
        idV[0]  = 8'h00;
        cmdV[0] = 16'hFFFF;
        waitIdle(0);
        checkOutput("takenPulsesMid", takenCnt[0], 1);
        checkFrame(0, 0, 8'h42, 16'h1280);
        idV[0]  = 8'h42;
        cmdV[0] = 16'h1280;

        // Asynchronous reset during bit 12 (quarters 50..53 of the frame).
        applyStimulus(0, 8'h42, 16'h1280);
        waitTaken(0);
        send[0] = 1'b0;
        repeat (205) @(negedge clk);
        checkOutput("midBusy", busy[0], 1'b1);
        checkOutput("midSiocLow", sioc[0], 1'b0);
        #2;
        rst_n   = 1'b0;
        send[0] = 1'b1;
        #1;
        checkOutput("abortSioc", sioc[0], 1'b1);
        checkOutput("abortSiod", siodA, 1'b1);
        checkOutput("abortBusy", busy[0], 1'b0);
        checkOutput("abortTaken", taken[0], 1'b0);
        repeat (3) @(negedge clk);
        clearMon();
        rst_n = 1'b1;
        waitTaken(0);
        send[0] = 1'b0;
        waitIdle(0);
        checkOutput("restartConds", startEv[0], 1);
        checkOutput("restartClks", dur[0], 468);
        checkFrame(0, 0, 8'h42, 16'h1280);

        // Fastest timing, no gap.
        clearMon();
        applyStimulus(1, 8'h42, 16'h1280);
        waitTaken(1);
        send[1] = 1'b0;
        waitIdle(1);
        checkOutput("frameClksB", dur[1], 113);
        checkOutput("takenPulsesB", takenCnt[1], 1);
        checkFrame(1, 0, 8'h42, 16'h1280);

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ov7670_sccb_sender.md
Name: ov7670_sccb_sender

Overview:
SCCB (I2C-compatible) 3-phase write master that sits directly downstream of the OV7670 register-table ROM. It consumes the 16-bit {reg_addr, reg_value} command word and the device id. It serialises each write onto sioc/siod as: start, id, don't-care bit, register, don't-care bit, value, don't-care bit, stop. A one-cycle `taken` pulse drives the ROM's `advance` input, so the table is stepped one entry per completed frame.

Parameters:
CLK_DIV, 125, system clocks per SCCB quarter-bit (50 MHz / (4*125) = 100 kHz sioc); legal range 1..65535.
GAP_Q, 4, idle quarters (sioc=1, siod released) enforced between frames; legal range 0..255.

Ports:
clk      input   1   system clock
rst_n    input   1   asynchronous active-low reset
send     input   1   level request; frame starts when high in IDLE (controller drives ~finished)
id       input   8   device write address (0x42 for OV7670); latched at frame start
command  input   16  [15:8] register address, [7:0] value; latched at frame start
taken    output  1   one-clk pulse on the cycle command/id are latched; wire to ROM advance
busy     output  1   high from latch cycle until GAP_Q completes
sioc     output  1   SCCB clock, push-pull
siod     inout   1   SCCB data; driven 0/1, or high-Z during don't-care bits and idle

Behaviour:
- Reset (async, rst_n=0): state=IDLE, sioc=1, siod=Z, taken=0, busy=0, quarter counter=0, bit counter=0. Reset asserted mid-frame aborts at once; no stop condition is generated. The next frame begins with a fresh start.
- Quarter tick: a divider counts 0..CLK_DIV-1 and asserts `qtick` for one clk at CLK_DIV-1. It is held at 0 in IDLE. With CLK_DIV=1, qtick is high every cycle.
- States: IDLE, START, BITS, STOP, GAP.
- IDLE: when send=1, on the same clk edge:
  - latch shift[26:0] = {id, 1'bZ-marker, command[15:8], marker, command[7:0], marker}, with the don't-care positions tracked by bit index 8/17/26;
  - pulse taken for exactly one cycle;
  - set busy=1 and go to START.
- START (2 quarters): q0 sioc=1 siod=1; q1 sioc=1 siod=0.
- BITS (27 bits x 4 quarters), MSB first:
  - q0: sioc=0, siod=bit (or Z on don't-care bits);
  - q1: sioc=0;
  - q2, q3: sioc=1.
  - siod changes only in q0, i.e. only while sioc is low.
- Don't-care bit: siod is released (Z). The slave ACK level is ignored; a NACK does not abort the frame.
- STOP (3 quarters): q0 sioc=0 siod=0; q1 sioc=1 siod=0; q2 sioc=1 siod=Z (released high).
- GAP: GAP_Q quarters with sioc=1, siod=Z. Then busy=0 and state=IDLE. With GAP_Q=0, GAP is skipped.
- Frame length: 2+108+3 = 113 quarters plus GAP_Q, i.e. (113+GAP_Q)*CLK_DIV clks from the taken cycle to busy falling.
- Outputs are registered. sioc/siod update on the clk following qtick.
- send held high after a frame: the next frame starts on the first IDLE cycle, with no extra bubble. The ROM's 2-cycle advance-to-command latency is always covered by the frame length.
- send deasserted mid-frame: the frame completes normally.
- command or id changing mid-frame: no effect, because both are latched.
- send=1 while rst_n=0: ignored.
- taken never asserts outside the IDLE->START transition.
- No FIFO; one frame is in flight at a time.

Decomposition:
- Shared package ov7670_pkg:
  - state enum (IDLE, START, BITS, STOP, GAP);
  - OV7670_WRITE_ID = 8'h42;
  - START_Q=2, BIT_Q=4, STOP_Q=3, FRAME_BITS=27;
  - don't-care bit indices 8, 17, 26.
- One sub-module: sccb_quarter_tick (the CLK_DIV divider with enable and async active-low reset, producing qtick).

Test Plan:
1. Reset then send=1, id=0x42, command=0x1280, CLK_DIV=4, GAP_Q=4 -> taken high exactly 1 clk. Decoded bytes at sioc rising edges are 0x42, 0x12, 0x80. siod=Z at bits 8/17/26. busy falls 117*4=468 clks after taken.
2. Start/stop check -> siod falls while sioc=1 before the first sioc low. siod rises while sioc=1 after the last bit. siod never toggles while sioc=1 inside BITS.
3. send held high with command stepping 0x1280, 0x1200, 0x1100 (ROM model with 2-cycle latency) -> three back-to-back frames carry those exact values, taken pulses 3 times, and the gap between stop and next start is 4 quarters.
4. Change command to 0xFFFF and id to 0x00 mid-frame -> the in-flight frame still shows 0x42/0x12/0x80; no extra taken.
5. Assert rst_n=0 during bit 12 of a frame -> sioc=1, siod=Z, busy=0 on the same cycle (async). After release with send=1, a new full frame starts with START.
6. CLK_DIV=1, GAP_Q=0 -> frame is exactly 113 clks from taken to busy falling, with correct bytes.
